// File: rtl/de_morgan_1a.sv
// De Morgan law 1(a): c = ~(a & b), with registered copy and input-change counter.
// Optional c vs c_alt equivalence self-check built when DE_MORGAN_SELF_CHECK_EN is defined.
module de_morgan_1a #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic [WIDTH-1:0] c_alt,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] w_alt;
    logic             w_chg;
    logic             w_chg_sat;

    logic [WIDTH-1:0] r_c_q;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic [CNT_W-1:0] r_chg_cnt;

    // Two independent gate structures so the self-check compares real logic
    assign w_nand = ~(a & b);
    assign w_alt  = ~a | ~b;

    assign c     = w_nand;
    assign c_alt = w_alt;

    assign w_chg     = (a != r_a_q) || (b != r_b_q);
    assign w_chg_sat = &r_chg_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c_q     <= '1;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_chg_cnt <= '0;
        end else begin
            r_c_q <= w_nand;
            r_a_q <= a;
            r_b_q <= b;
            if (w_chg && !w_chg_sat) begin
                r_chg_cnt <= r_chg_cnt + 1'b1;
            end
        end
    end

    assign c_q     = r_c_q;
    assign chg_cnt = r_chg_cnt;

`ifdef DE_MORGAN_SELF_CHECK_EN
    logic             w_diff;
    logic             w_mis_sat;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_mismatch_cnt;

    assign w_diff    = (w_nand != w_alt);
    assign w_mis_sat = &r_mismatch_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (w_diff) begin
            r_mismatch <= 1'b1;
            if (!w_mis_sat) begin
                r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            end
        end
    end

    assign mismatch     = r_mismatch;
    assign mismatch_cnt = r_mismatch_cnt;
`else
    assign mismatch     = 1'b0;
    assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_de_morgan_1a.sv
// Randomized and directed bench for de_morgan_1a against a behavioural model.
// Uses an 8-bit/16-bit instance and a 1-bit/3-bit instance for saturation.
module tb_de_morgan_1a;

    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int SCW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic [W-1:0]  c, c_q, c_alt;
    logic [CW-1:0] chg_cnt, mismatch_cnt;
    logic          mismatch;

    logic           sa, sb;
    logic           s_c, s_cq, s_alt;
    logic [SCW-1:0] s_chg, s_mcnt;
    logic           s_mis;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    de_morgan_1a #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .c(c), .c_q(c_q), .c_alt(c_alt),
        .chg_cnt(chg_cnt), .mismatch(mismatch),
        .mismatch_cnt(mismatch_cnt)
    );

    de_morgan_1a #(.WIDTH(1), .CNT_W(SCW)) u_sat (
        .clk(clk), .rst(rst), .a(sa), .b(sb),
        .c(s_c), .c_q(s_cq), .c_alt(s_alt),
        .chg_cnt(s_chg), .mismatch(s_mis),
        .mismatch_cnt(s_mcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-bit truth-table NAND: result bit is 0 only when both bits are 1
    function automatic logic [31:0] nand_ref(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[i] = (x[i] == 1'b1 && y[i] == 1'b1) ? 1'b0 : 1'b1;
        return r;
    endfunction

    logic [W-1:0] m_cq, m_pa, m_pb;
    int           m_cnt;
    logic         m_scq, m_spa, m_spb;
    int           m_scnt;

    always @(posedge clk) begin
        if (rst) begin
            m_cq = '1; m_pa = '0; m_pb = '0; m_cnt = 0;
            m_scq = 1'b1; m_spa = 1'b0; m_spb = 1'b0; m_scnt = 0;
        end else begin
            if (a != m_pa || b != m_pb)
                m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
            m_cq = W'(nand_ref(32'(a), 32'(b), W));
            m_pa = a; m_pb = b;
            if (sa != m_spa || sb != m_spb)
                m_scnt = (m_scnt < (1 << SCW) - 1) ? m_scnt + 1 : m_scnt;
            m_scq = nand_ref(32'(sa), 32'(sb), 1) != 0;
            m_spa = sa; m_spb = sb;
        end
    end

    task automatic tick(input logic [W-1:0] na, input logic [W-1:0] nb,
                        input logic nsa, input logic nsb, input logic nr);
        a = na; b = nb; sa = nsa; sb = nsb; rst = nr;
        #1;
        chk("c",     32'(c),     nand_ref(32'(a), 32'(b), W));
        chk("c_alt", 32'(c_alt), nand_ref(32'(a), 32'(b), W));
        chk("s_c",   32'(s_c),   nand_ref(32'(sa), 32'(sb), 1));
        chk("s_alt", 32'(s_alt), nand_ref(32'(sa), 32'(sb), 1));
        @(negedge clk);
        chk("c_q",     32'(c_q),          32'(m_cq));
        chk("chg_cnt", 32'(chg_cnt),      32'(m_cnt));
        chk("mis",     32'(mismatch),     32'd0);
        chk("mis_cnt", 32'(mismatch_cnt), 32'd0);
        chk("s_cq",    32'(s_cq),         32'(m_scq));
        chk("s_chg",   32'(s_chg),        32'(m_scnt));
        chk("s_mis",   32'(s_mis),        32'd0);
    endtask

    initial begin
        logic [W-1:0] ta, tb;
        logic         tsa, tsb;
        logic [1:0]   p;
        rst = 1'b1; a = '0; b = '0; sa = 1'b0; sb = 1'b0;
        @(negedge clk);

        // reset held with a=b=1
        tick('1, '1, 1'b1, 1'b1, 1'b1);
        tick('1, '1, 1'b1, 1'b1, 1'b1);
        chk("rst_c",    32'(s_c),     32'd0);
        chk("rst_cq",   32'(s_cq),    32'd1);
        chk("rst_chg",  32'(chg_cnt), 32'd0);
        chk("rst_mis",  32'(mismatch), 32'd0);

        // truth table on the 1-bit instance
        for (int i = 0; i < 4; i++) begin
            p = 2'(i);
            tick('0, '0, p[1], p[0], 1'b0);
            chk("tt_c",  32'(s_c),  (i == 3) ? 32'd0 : 32'd1);
            chk("tt_cq", 32'(s_cq), (i == 3) ? 32'd0 : 32'd1);
            tick('0, '0, p[1], p[0], 1'b0);
        end

        // change counting: a every 4, b every 2 cycles
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        ta = '0; tb = '0;
        for (int i = 1; i <= 16; i++) begin
            if (i % 2 == 0) tb = ~tb;
            if (i % 4 == 0) ta = ~ta;
            tick(ta, tb, 1'b0, 1'b0, 1'b0);
        end
        chk("chg16", 32'(chg_cnt), 32'd8);

        // saturation on 3-bit counter
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        tsa = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tsa = ~tsa;
            tick('0, '0, tsa, 1'b0, 1'b0);
            if (i == 6) chk("sat7", 32'(s_chg), 32'd7);
        end
        chk("sat_hold", 32'(s_chg), 32'd7);

        // reset mid-operation at count 5
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) tick(W'(i), '0, 1'b0, 1'b0, 1'b0);
        chk("pre5", 32'(chg_cnt), 32'd5);
        tick(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1);
        chk("mid_chg", 32'(chg_cnt), 32'd0);
        chk("mid_cq",  32'(c_q),     32'hFF);
        tick(8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("resume", 32'(chg_cnt), 32'd1);

        // vector pattern then random pairs
        tick(8'hF0, 8'hCC, 1'b0, 1'b0, 1'b0);
        chk("vec_c",  32'(c),   32'h3F);
        chk("vec_cq", 32'(c_q), 32'h3F);
        for (int i = 0; i < 100; i++) begin
            ta = W'($urandom); tb = W'($urandom);
            tsa = 1'($urandom); tsb = 1'($urandom);
            tick(ta, tb, tsa, tsb, ($urandom_range(0, 49) == 0));
        end
        chk("vec_mis",  32'(mismatch),     32'd0);
        chk("vec_mcnt", 32'(mismatch_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
